// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: radix-2 shift-add multiply, restoring divide, 64-bit result + NZCV.
// Optional MDU_EARLY_OUT_EN: a zero operand B finishes straight from IDLE in one edge.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags,
    output logic               busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL = 3'b000, OP_UMULL = 3'b100, OP_SMULL = 3'b110,
        OP_UDIV = 3'b001, OP_SDIV = 3'b011
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d, op_in;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sgn_quot_q, sgn_quot_d, sgn_rem_q, sgn_rem_d;
    logic [3:0]         flags_q, flags_d;
    logic               resp_valid_q, resp_valid_d, busy_q, busy_d, req_ready_q, req_ready_d;

    logic               in_signed;
    logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] fix_res;
    logic               fix_n, fix_z;

    always_comb begin
        case (op)
            3'b100:  op_in = OP_UMULL;
            3'b110:  op_in = OP_SMULL;
            3'b001:  op_in = OP_UDIV;
            3'b011:  op_in = OP_SDIV;
            default: op_in = OP_MUL;
        endcase
        in_signed = (op_in == OP_SMULL) || (op_in == OP_SDIV);
    end

    // One datapath step; acc holds {hi, lo} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, b_q};
        div_ge     = ~div_diff[WIDTH];
    end

    always_comb begin
        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
        if (b_q == '0) begin
            quo = '0;
            rem = a_q;
        end
        if (op_q == OP_SDIV) begin
            if (sgn_quot_q) quo = ~quo + 1'b1;
            if (sgn_rem_q)  rem = ~rem + 1'b1;
        end
        case (op_q)
            OP_UMULL:         fix_res = acc_q;
            OP_SMULL:         fix_res = sgn_quot_q ? (~acc_q + 1'b1) : acc_q;
            OP_UDIV, OP_SDIV: fix_res = {rem, quo};
            default:          fix_res = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        endcase
        fix_n = op_q[2] ? fix_res[2*WIDTH-1] : fix_res[WIDTH-1];
        fix_z = op_q[2] ? (fix_res == '0) : (fix_res[WIDTH-1:0] == '0);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sgn_quot_d = sgn_quot_q;
        sgn_rem_d  = sgn_rem_q;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d       = op_in;
                    a_d        = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
                    b_d        = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
                    sgn_quot_d = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_rem_d  = in_signed && a[WIDTH-1];
                    acc_d      = {{WIDTH{1'b0}}, a_d};
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = S_RUN;
`ifdef MDU_EARLY_OUT_EN
                    if (b == '0) begin
                        result_d = op_in[0] ? {a, {WIDTH{1'b0}}} : '0;
                        flags_d  = 4'b0100;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = op_q[0] ? {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                                   acc_q[WIDTH-2:0], div_ge}
                                : {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                result_d = fix_res;
                flags_d  = {fix_n, fix_z, 2'b00};
                state_d  = S_DONE;
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
        resp_valid_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        req_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sgn_quot_q   <= 1'b0;
            sgn_rem_q    <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sgn_quot_q   <= sgn_quot_d;
            sgn_rem_q    <= sgn_rem_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign result     = result_q;
    assign flags      = flags_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: arithmetic reference model, per-cycle response compare, directed literals.
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
    } exp_t;
    exp_t exp_q[$];

    logic [63:0] got_res;
    logic [3:0]  got_flg;
    int          exp_lat;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .a(a), .b(b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        logic [31:0] q, r;
        bit          lng;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lng = 1'b0;
        case (o)
            3'b100: begin p = {32'h0, x} * {32'h0, y}; lng = 1'b1; end
            3'b110: begin p = 64'(sx * sy); lng = 1'b1; end
            3'b001: begin
                if (y == 0) begin q = 0; r = x; end
                else begin q = x / y; r = x % y; end
                p = {r, q};
            end
            3'b011: begin
                if (y == 0) begin q = 0; r = x; end
                else begin sq = sx / sy; sr = sx % sy; q = sq[31:0]; r = sr[31:0]; end
                p = {r, q};
            end
            default: begin p = {32'h0, x} * {32'h0, y}; p[63:32] = 32'h0; end
        endcase
        e.res = p;
        e.flg = {lng ? p[63] : p[31], lng ? (p == 64'h0) : (p[31:0] == 32'h0), 2'b00};
        return e;
    endfunction

    function automatic int lat_of(input logic [31:0] y);
`ifdef MDU_EARLY_OUT_EN
        return (y == 0) ? 1 : 34;
`else
        return 34;
`endif
    endfunction

    // Every cycle a response is presented it must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got result=%h want no response", result);
            end else begin
                chk("resp_result", result, exp_q[0].res);
                chk("resp_flags", 64'(flags), 64'(exp_q[0].flg));
                chk("resp_req_ready", 64'(req_ready), 64'd0);
                chk("resp_busy", 64'(busy), 64'd1);
            end
        end
    end

    // Call at a negedge; returns 1ns after the accept edge.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        req_valid = 1'b1; op = o; a = x; b = y;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got req_ready=0 want 1");
        end
        @(posedge clk);
        exp_q.push_back(model(o, x, y));
        exp_lat = lat_of(y);
        #1;
        req_valid = 1'b0;
    endtask

    // Latency counts edges with the accept edge as 1; stray input changes must be ignored.
    task automatic wait_resp();
        int lat = 1;
        forever begin
            @(negedge clk);
            if (resp_valid || lat > 100) break;
            a = $urandom; b = $urandom; op = 3'($urandom);
            lat++;
        end
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got resp_valid=0 want 1");
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        got_res = result;
        got_flg = flags;
    endtask

    task automatic finish_resp(input int hold);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_result", result, got_res);
            chk("hold_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [63:0] wr, input logic [3:0] wf);
        send(o, x, y);
        wait_resp();
        chk({name, "_result"}, got_res, wr);
        chk({name, "_flags"}, 64'(got_flg), 64'(wf));
        finish_resp(0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // Pin the reference model with hand-computed values
        e = model(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("model_umull", {e.res}, 64'hFFFFFFFE_00000001);
        e = model(3'b011, 32'hFFFFFFF9, 32'h2);
        chk("model_sdiv", {e.res}, 64'hFFFFFFFF_FFFFFFFD);

        directed("umull", 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 4'b1000);
        directed("smull", 3'b110, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 4'b1000);
        directed("mul", 3'b000, 32'h10000, 32'h10000, 64'h0, 4'b0100);
        directed("sdiv_neg", 3'b011, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 4'b1000);
        directed("sdiv_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 4'b1000);
        directed("udiv_zero", 3'b001, 32'd100, 32'd0, 64'h00000064_00000000, 4'b0100);
        directed("sdiv_zero", 3'b011, 32'hFFFFFF9C, 32'd0, 64'hFFFFFF9C_00000000, 4'b0100);

        // Backpressure with a pending request, then acceptance on the first IDLE cycle
        send(3'b001, 32'd1000, 32'd7);
        wait_resp();
        req_valid = 1'b1; op = 3'b100; a = 32'h12345678; b = 32'h9ABCDEF0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_result", result, got_res);
            chk("bp_flags", 64'(flags), 64'(got_flg));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        finish_resp(0);
        chk("bp_idle_ready", 64'(req_ready), 64'd1);
        send(3'b100, 32'h12345678, 32'h9ABCDEF0);
        chk("bp_accept_busy", 64'(busy), 64'd1);
        wait_resp();
        finish_resp(1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            send(ro, ra, rb);
            wait_resp();
            finish_resp(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset at RUN cycle 10 aborts the operation
        send(3'b100, 32'hDEADBEEF, 32'h1234567);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_flags", 64'(flags), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        directed("udiv_after_rst", 3'b001, 32'd9, 32'd3, 64'h00000000_00000003, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide responder for the datapath.
- Accepts one operation per request/response handshake; operands and op use the same MulFunct encoding the ALU decodes.
- Produces a 64-bit result and NZCV flags, so long multiplies and divides leave the single-cycle ALU critical path.
- Sits beside the ALU in the execute stage; the controller stalls while a response is outstanding.

Parameters:
WIDTH, 32, operand width; latency and counter width derive from it.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  000 MUL, 100 UMULL, 110 SMULL, 001 UDIV, 011 SDIV; any other code executes as MUL
a  input  WIDTH  operand A / dividend
b  input  WIDTH  operand B / divisor
resp_valid  output  1  result and flags valid
resp_ready  input  1  consumer takes the result
result  output  2*WIDTH  product, or {remainder, quotient}
flags  output  4  {N,Z,C,V}
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE; result=0, flags=0, resp_valid=0, busy=0, counter=0, internal registers cleared; req_ready=1 once reset is released.
- Reset asserted mid-operation aborts it immediately. No partial result is ever presented.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - Accept on req_valid && req_ready: latch op, a, b; load counter=WIDTH-1; go to RUN.
  - Signed ops latch |a| and |b| and record sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
- RUN: one iteration per cycle for exactly WIDTH cycles; exit to FIX when counter==0.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX (1 cycle):
  - Negate the product if signed and sign_q=1.
  - SDIV: negate the quotient if sign_q=1; negate the remainder if sign_r=1.
  - Compute flags; go to DONE.
- DONE: resp_valid=1; result and flags held stable until resp_ready=1, then go to IDLE. req_ready=0 throughout.
- Latency: resp_valid rises exactly WIDTH+2 edges after the accept edge (34 for WIDTH=32).
- No back-to-back overlap: the next accept is possible at the earliest one cycle after the response handshake.
- Result layout:
  - MUL: result[WIDTH-1:0] = low product; upper half = 0.
  - UMULL/SMULL: full 2*WIDTH product.
  - UDIV/SDIV: result[WIDTH-1:0] = quotient, result[2W-1:W] = remainder.
- SDIV semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- SDIV boundary: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero: quotient=0, remainder=a, using the normal full latency.
- Flags:
  - N = result[2W-1] for UMULL/SMULL, else result[W-1].
  - Z = (result==0) for long multiplies, else (result[W-1:0]==0).
  - C=0, V=0 always.
- Simultaneous resp_ready and a new req_valid in DONE: only the response completes; the request waits for IDLE.
- Input changes on a, b, op while not in IDLE are ignored.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: if b==0 at accept, skip RUN and FIX and go directly to DONE with the final result already formed. Multiplies give 0 with Z=1; divides give q=0, r=a. resp_valid rises 1 edge after accept.
- Undefined: every operation takes the full WIDTH+2 latency.

Test Plan:
- UMULL a=0xFFFFFFFF b=0xFFFFFFFF -> result 0xFFFFFFFE_00000001, flags 1000; resp_valid exactly 34 edges after accept.
- SMULL a=0xFFFFFFFE (-2) b=3 -> result 0xFFFFFFFF_FFFFFFFA, flags 1000. MUL a=0x10000 b=0x10000 -> result 0, flags 0100.
- SDIV a=0xFFFFFFF9 (-7) b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. SDIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- UDIV a=100 b=0 -> quotient 0, remainder 100, flags 0100. Latency is 34 without MDU_EARLY_OUT_EN and 1 with it.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE with req_valid=1 -> result and flags stable, req_ready=0. Release -> the new request is accepted on the first IDLE cycle.
- Drive reset low at RUN cycle 10 -> resp_valid, result, flags and busy clear immediately. After release, req_ready=1 and a fresh UDIV 9/3 returns quotient 3, remainder 0.
